// File: rtl/morse_decoder_if.sv
// Byte delivery channel between the Morse decoder and the serial TX path.
// The decoder drives data/valid/overrun and the consumer answers with ready.
interface morse_decoder_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       overrun;

  modport master (output data, output valid, output overrun, input ready);
  modport slave  (input data, input valid, input overrun, output ready);
endinterface

// File: rtl/morse_decoder.sv
// Morse key receiver: synchronises and debounces a raw key, times marks and
// spaces in dot units, decodes ITU Morse into ASCII (plus word spaces) and
// hands each byte over through a one-entry valid/ready holding register.
module morse_decoder #(
  parameter int UNIT_CYCLES     = 1_440_000,
  parameter int DEBOUNCE_CYCLES = 240_000
) (
  input  logic            clk_24,
  input  logic            rst_n,
  input  logic            key,
  morse_decoder_if.master tx
);

  localparam int PRE_W = $clog2(UNIT_CYCLES + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(UNIT_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MARK, GAP, WORD} state_t;

  state_t           state, next_state;
  logic             key_s1, key_s2, key_db, key_db_prev;
  logic [DB_W-1:0]  db_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic [3:0]       units;
  logic [5:0]       sym;
  logic [2:0]       sym_len;
  logic             sym_err;
  logic             rise, fall;
  logic             append, emit;
  logic [7:0]       emit_byte;
  logic [7:0]       hold_byte;
  logic             hold_full, drop;

  // Element pattern (1 = dash, first element highest) to ASCII; '?' otherwise.
  function automatic logic [7:0] decode(input logic [2:0] len, input logic [5:0] pat,
                                        input logic err);
    logic [7:0] ch;
    ch = 8'h3F;
    if (!err) begin
      case ({len, pat})
        {3'd2, 6'b000001}: ch = 8'h41;
        {3'd4, 6'b001000}: ch = 8'h42;
        {3'd4, 6'b001010}: ch = 8'h43;
        {3'd3, 6'b000100}: ch = 8'h44;
        {3'd1, 6'b000000}: ch = 8'h45;
        {3'd4, 6'b000010}: ch = 8'h46;
        {3'd3, 6'b000110}: ch = 8'h47;
        {3'd4, 6'b000000}: ch = 8'h48;
        {3'd2, 6'b000000}: ch = 8'h49;
        {3'd4, 6'b000111}: ch = 8'h4A;
        {3'd3, 6'b000101}: ch = 8'h4B;
        {3'd4, 6'b000100}: ch = 8'h4C;
        {3'd2, 6'b000011}: ch = 8'h4D;
        {3'd2, 6'b000010}: ch = 8'h4E;
        {3'd3, 6'b000111}: ch = 8'h4F;
        {3'd4, 6'b000110}: ch = 8'h50;
        {3'd4, 6'b001101}: ch = 8'h51;
        {3'd3, 6'b000010}: ch = 8'h52;
        {3'd3, 6'b000000}: ch = 8'h53;
        {3'd1, 6'b000001}: ch = 8'h54;
        {3'd3, 6'b000001}: ch = 8'h55;
        {3'd4, 6'b000001}: ch = 8'h56;
        {3'd3, 6'b000011}: ch = 8'h57;
        {3'd4, 6'b001001}: ch = 8'h58;
        {3'd4, 6'b001011}: ch = 8'h59;
        {3'd4, 6'b001100}: ch = 8'h5A;
        {3'd5, 6'b011111}: ch = 8'h30;
        {3'd5, 6'b001111}: ch = 8'h31;
        {3'd5, 6'b000111}: ch = 8'h32;
        {3'd5, 6'b000011}: ch = 8'h33;
        {3'd5, 6'b000001}: ch = 8'h34;
        {3'd5, 6'b000000}: ch = 8'h35;
        {3'd5, 6'b010000}: ch = 8'h36;
        {3'd5, 6'b011000}: ch = 8'h37;
        {3'd5, 6'b011100}: ch = 8'h38;
        {3'd5, 6'b011110}: ch = 8'h39;
        default:           ch = 8'h3F;
      endcase
    end
    return ch;
  endfunction

  assign rise = key_db & ~key_db_prev;
  assign fall = ~key_db & key_db_prev;

  // Two-flop synchroniser plus debouncer: a new level must persist for the full window.
  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      key_s1      <= 1'b0;
      key_s2      <= 1'b0;
      key_db      <= 1'b0;
      key_db_prev <= 1'b0;
      db_cnt      <= '0;
    end else begin
      key_s1      <= key;
      key_s2      <= key_s1;
      key_db_prev <= key_db;
      if (key_s2 != key_db) begin
        if (db_cnt == DB_LAST) begin
          key_db <= key_s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Unit timer: both counters restart on every debounced edge, units saturate at 15.
  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      units   <= 4'd0;
    end else if (rise || fall) begin
      pre_cnt <= '0;
      units   <= 4'd0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      if (units != 4'd15) units <= units + 4'd1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state, element capture and character/space emission decisions.
  always_comb begin
    next_state = state;
    append     = 1'b0;
    emit       = 1'b0;
    emit_byte  = 8'h00;
    case (state)
      IDLE: if (rise) next_state = MARK;
      MARK: if (fall) begin
        append     = 1'b1;
        next_state = GAP;
      end
      GAP: begin
        if (units == 4'd3) begin
          emit       = 1'b1;
          emit_byte  = decode(sym_len, sym, sym_err);
          next_state = rise ? MARK : WORD;
        end else if (rise) begin
          next_state = MARK;
        end
      end
      WORD: begin
        if (rise) begin
          next_state = MARK;
        end else if (units == 4'd7) begin
          emit       = 1'b1;
          emit_byte  = 8'h20;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Symbol register: shift in dots/dashes, flag a seventh element, clear after emit.
  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      sym     <= 6'd0;
      sym_len <= 3'd0;
      sym_err <= 1'b0;
    end else if (emit) begin
      sym     <= 6'd0;
      sym_len <= 3'd0;
      sym_err <= 1'b0;
    end else if (append) begin
      if (sym_len == 3'd6) begin
        sym_err <= 1'b1;
      end else begin
        sym     <= {sym[4:0], (units >= 4'd2)};
        sym_len <= sym_len + 3'd1;
      end
    end
  end

  // Holding register: load when empty or draining, otherwise drop and flag overrun.
  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      hold_byte <= 8'h00;
      hold_full <= 1'b0;
      drop      <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (emit) begin
        if (!hold_full || tx.ready) begin
          hold_byte <= emit_byte;
          hold_full <= 1'b1;
        end else begin
          drop <= 1'b1;
        end
      end else if (hold_full && tx.ready) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign tx.data    = hold_byte;
  assign tx.valid   = hold_full;
  assign tx.overrun = drop;

endmodule

// File: tb/tb_morse_decoder.sv
// Testbench for morse_decoder: random Morse traffic against a table-driven
// reference, with a scoreboard queue drained by an independent monitor.
module tb_morse_decoder;

  localparam int UNIT = 100;
  localparam int DEB  = 10;

  logic clk_24 = 1'b0;
  logic rst_n;
  logic key;

  morse_decoder_if tx ();

  morse_decoder #(.UNIT_CYCLES(UNIT), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_24 (clk_24),
    .rst_n  (rst_n),
    .key    (key),
    .tx     (tx)
  );

  always #5 clk_24 = ~clk_24;

  int         n_checks  = 0;
  int         n_pass    = 0;
  int         n_rx      = 0;
  int         n_ovr     = 0;
  int         exp_ovr   = 0;
  bit         slot_full = 1'b0;
  logic       ovr_prev  = 1'b0;
  logic [7:0] exp_q[$];

  string morse_tab[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                           "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                           "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                           "-.--", "--..", "-----", ".----", "..---", "...--",
                           "....-", ".....", "-....", "--...", "---..", "----."};

  // Reference: look the dot/dash string up in the ITU table.
  function automatic logic [7:0] ref_decode(input string code);
    if (code.len() > 6) return 8'h3F;
    for (int i = 0; i < 36; i++)
      if (code == morse_tab[i]) return (i < 26) ? 8'(65 + i) : 8'(48 + i - 26);
    return 8'h3F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_24);
      #1;
    end
  endtask

  // A byte with nowhere to go (slot occupied, consumer stalled) becomes an overrun.
  task automatic expect_byte(input logic [7:0] b);
    if (!tx.ready && slot_full) begin
      exp_ovr++;
    end else begin
      exp_q.push_back(b);
      if (!tx.ready) slot_full = 1'b1;
    end
  endtask

  // Key one character with random element timing, then hold the key up for gap cycles.
  task automatic applyStimulus(input string code, input int gap);
    int d;
    if (gap >= 3 * UNIT) expect_byte(ref_decode(code));
    if (gap >= 7 * UNIT) expect_byte(8'h20);
    for (int i = 0; i < code.len(); i++) begin
      key = 1'b1;
      d = (code[i] == 8'h2D) ? int'($urandom_range(450, 250)) : int'($urandom_range(150, 50));
      tick(d);
      key = 1'b0;
      if (i < code.len() - 1) begin
        d = int'($urandom_range(180, 60));
        tick(d);
      end
    end
    tick(gap);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  // Monitor: every accepted byte is popped from the scoreboard and compared.
  initial begin
    forever begin
      @(negedge clk_24);
      if (rst_n && tx.valid && tx.ready) begin
        n_rx++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", tx.data);
        end else begin
          checkOutput("rx_byte", tx.data, exp_q.pop_front());
        end
      end
      if (tx.overrun) begin
        n_ovr++;
        checkOutput("overrun_width", ovr_prev, 0);
      end
      ovr_prev = tx.overrun;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rx0;
    int idx;
    int gap;

    rst_n    = 1'b0;
    key      = 1'b0;
    tx.ready = 1'b1;
    tick(5);
    checkOutput("reset_data", tx.data, 8'h00);
    checkOutput("reset_valid", tx.valid, 0);
    checkOutput("reset_overrun", tx.overrun, 0);
    rst_n = 1'b1;
    tick(20);

    $display("[TB] letter A then word space");
    rx0 = n_rx;
    applyStimulus(".-", 900);
    wait_drain();
    checkOutput("a_byte_count", n_rx - rx0, 2);

    $display("[TB] SOS");
    applyStimulus("...", 400);
    applyStimulus("---", 400);
    applyStimulus("...", 900);
    wait_drain();
    checkOutput("sos_overrun", n_ovr, exp_ovr);

    $display("[TB] key bounce rejection");
    rx0 = n_rx;
    repeat (20) begin
      key = ~key;
      tick(3);
    end
    key = 1'b0;
    tick(400);
    checkOutput("glitch_no_byte", n_rx - rx0, 0);
    applyStimulus(".", 900);
    wait_drain();

    $display("[TB] stalled consumer and overrun");
    tx.ready = 1'b0;
    applyStimulus(".", 400);
    applyStimulus("-", 400);
    checkOutput("hold_valid", tx.valid, 1);
    checkOutput("hold_data", tx.data, 8'h45);
    checkOutput("overrun_count", n_ovr, exp_ovr);
    tx.ready  = 1'b1;
    slot_full = 1'b0;
    tick(2);
    checkOutput("accept_valid", tx.valid, 0);
    expect_byte(8'h20);
    tick(500);
    wait_drain();

    $display("[TB] invalid patterns");
    applyStimulus(".......", 900);
    applyStimulus(".-.-", 900);
    wait_drain();

    $display("[TB] random characters");
    for (int k = 0; k < 8; k++) begin
      idx = int'($urandom_range(35, 0));
      gap = (k == 7 || $urandom_range(3, 0) == 0) ? int'($urandom_range(1000, 800))
                                                  : int'($urandom_range(550, 350));
      applyStimulus(morse_tab[idx], gap);
    end
    wait_drain();
    checkOutput("random_overrun", n_ovr, exp_ovr);

    $display("[TB] reset in the middle of a dash");
    key = 1'b1;
    tick(100);
    key = 1'b0;
    tick(120);
    key = 1'b1;
    tick(150);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", tx.valid, 0);
    checkOutput("midreset_data", tx.data, 8'h00);
    tick(5);
    rst_n = 1'b1;
    tick(3);
    key = 1'b0;
    rx0 = n_rx;
    tick(1200);
    checkOutput("midreset_no_byte", n_rx - rx0, 0);
    checkOutput("final_queue", exp_q.size(), 0);
    checkOutput("final_overrun", n_ovr, exp_ovr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
